// File: rtl/aes_pkg.sv
// aes_pkg: AES key-schedule mode enum, per-mode sizes and GF(2^8) helpers.
package aes_pkg;
   typedef enum logic [1:0] {
      AES_128          = 2'b00,
      AES_192          = 2'b01,
      AES_256          = 2'b10,
      AES_MODE_ILLEGAL = 2'b11
   } aes_mode_e;

   typedef enum logic {ST_IDLE, ST_EXPAND} kx_state_e;

   function automatic logic [3:0] nk_of(input aes_mode_e m);
      return (m == AES_256) ? 4'd8 : (m == AES_192) ? 4'd6 : 4'd4;
   endfunction

   function automatic logic [3:0] nr_of(input aes_mode_e m);
      return (m == AES_256) ? 4'd14 : (m == AES_192) ? 4'd12 : 4'd10;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse (0 maps to 0), then the affine map
   function automatic logic [7:0] sbox_of(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction
endpackage

// File: rtl/aes_key_word_step.sv
// aes_key_word_step: one key-schedule word, w[i] = w[i-Nk] ^ f(w[i-1]).
module aes_key_word_step
   import aes_pkg::*;
(
   input  logic [31:0] prev,
   input  logic [31:0] back,
   input  logic        rot,
   input  logic        sub,
   input  logic [7:0]  rcon,
   output logic [31:0] word
);
   logic [31:0] t_in;
   logic [31:0] s;
   assign t_in = rot ? {prev[23:0], prev[31:24]} : prev;
   for (genvar g = 0; g < 4; g++) begin : g_sb
      aes_sbox u_sbox (.a(t_in[8*g +: 8]), .y(s[8*g +: 8]));
   end
   assign word = back ^ (rot ? (s ^ {rcon, 24'h0}) : sub ? s : prev);
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box, one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   assign y = sbox_of(a);
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128/192/256 key expansion into a round-key file
// with a registered round-indexed read port.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int WPC    = 1,
   parameter int NUM_RK = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         ready,
   input  logic [1:0]   mode,
   input  logic [255:0] key_in,
   input  logic         zeroize,
   output logic         busy,
   output logic         done,
   output logic         err,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         rd_valid
);
   localparam int NW = 4 * NUM_RK;
   kx_state_e   state;
   aes_mode_e   cur_mode;
   logic [31:0] w [NW];
   logic [5:0]  cnt;
   logic [5:0]  total;
   logic [5:0]  left;
   logic [5:0]  adv;
   logic [5:0]  rd_base;
   logic [7:0]  rcon;
   logic [3:0]  nk;
   logic [7:0]  rc [WPC+1];
   logic [31:0] nxt [WPC];
   logic        rd_ok;
   assign nk      = nk_of(cur_mode);
   assign total   = 6'(4 * (int'(nr_of(cur_mode)) + 1));
   assign left    = total - cnt;
   assign adv     = (left < 6'(WPC)) ? left : 6'(WPC);
   assign rd_base = {rd_round, 2'b00};
   // uses the pre-edge count, so a round finishing this cycle is reported next cycle
   assign rd_ok   = (rd_round <= nr_of(cur_mode)) && (({1'b0, rd_base} + 7'd4) <= {1'b0, cnt});
   assign rc[0]   = rcon;
   for (genvar j = 0; j < WPC; j++) begin : g_step
      logic [5:0]  i;
      logic [31:0] prev;
      logic        rot;
      logic        sub;
      assign i   = cnt + 6'(j);
      assign rot = (i % {2'b00, nk}) == 6'd0;
      assign sub = (nk == 4'd8) && (i[2:0] == 3'd4);
      assign rc[j+1] = rot ? xtime(rc[j]) : rc[j];
      if (j == 0) begin : g_first
         assign prev = w[cnt - 6'd1];
      end else begin : g_chain
         assign prev = nxt[j-1];
      end
      aes_key_word_step u_step (
         .prev (prev),
         .back (w[i - {2'b00, nk}]),
         .rot  (rot),
         .sub  (sub),
         .rcon (rc[j]),
         .word (nxt[j])
      );
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= ST_IDLE;
         cur_mode <= AES_128;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         rd_key   <= '0;
         cnt      <= '0;
         rcon     <= 8'h01;
         for (int n = 0; n < NW; n++) w[n] <= '0;
      end else if (zeroize) begin
         state    <= ST_IDLE;
         cur_mode <= AES_128;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         rd_key   <= '0;
         cnt      <= '0;
         rcon     <= 8'h01;
         for (int n = 0; n < NW; n++) w[n] <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= rd_ok;
         rd_key   <= rd_ok ? {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]} : '0;
         if (state == ST_IDLE) begin
            if (start && ready) begin
               if (mode == AES_MODE_ILLEGAL) begin
                  err <= 1'b1;
               end else begin
                  cur_mode <= aes_mode_e'(mode);
                  cnt      <= 6'(nk_of(aes_mode_e'(mode)));
                  rcon     <= 8'h01;
                  state    <= ST_EXPAND;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  for (int n = 0; n < 8; n++)
                     if (n < int'(nk_of(aes_mode_e'(mode)))) w[n] <= key_in[255 - 32*n -: 32];
               end
            end
         end else if (cnt == total) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
         end else begin
            for (int j = 0; j < WPC; j++)
               if (6'(j) < adv) w[cnt + 6'(j)] <= nxt[j];
            cnt  <= cnt + adv;
            rcon <= rc[WPC];
         end
      end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed FIPS-197 vectors against a WPC=1 and a WPC=4 instance.
module tb_aes_key_expand_seq;
   localparam logic [255:0] K1    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] R1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R1_2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] R1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [255:0] K2    = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [127:0] R2_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [255:0] K3    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R3_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   logic         clk = 1'b0;
   logic         rst_n, start, zeroize;
   logic [1:0]   mode;
   logic [255:0] key_in;
   logic [3:0]   rd_round;
   logic         ready, busy, done, err, rd_valid;
   logic [127:0] rd_key;
   logic         ready4, busy4, done4, err4, rd_valid4;
   logic [127:0] rd_key4;
   logic         saw;
   int           vectors = 0;
   int           errors = 0;
   int           dc, dc4, rise;

   always #5 clk = ~clk;

   aes_key_expand_seq #(.WPC(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .mode(mode), .key_in(key_in),
      .zeroize(zeroize), .busy(busy), .done(done), .err(err), .rd_round(rd_round),
      .rd_key(rd_key), .rd_valid(rd_valid)
   );

   aes_key_expand_seq #(.WPC(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready4), .mode(mode), .key_in(key_in),
      .zeroize(zeroize), .busy(busy4), .done(done4), .err(err4), .rd_round(rd_round),
      .rd_key(rd_key4), .rd_valid(rd_valid4)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] r);
      rd_round = r;
      tick();
   endtask

   // poke > 0 raises start (with a different mode) on that cycle of the expansion
   task automatic expand(input logic [1:0] m, input logic [255:0] k, input int poke,
                         output int d, output int d4, output int first);
      mode = m;
      key_in = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_accept", {ready, busy}, 2'b01);
      d = -1;
      d4 = -1;
      first = -1;
      for (int c = 1; c <= 80 && d < 0; c++) begin
         tick();
         if (first < 0 && rd_valid) first = c;
         if (d4 < 0 && done4) d4 = c;
         if (done) d = c;
         start = (c == poke);
         if (c == poke) mode = 2'b01;
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; mode = 2'b00; key_in = '0; rd_round = 4'd0;
      repeat (2) tick();
      check("rst_outputs", {ready, busy, done, err, rd_valid}, 5'b10000);
      check("rst_rd_key", rd_key, 128'h0);
      rst_n = 1'b1;
      tick();

      rd_round = 4'd2;
      expand(2'b00, K1, 5, dc, dc4, rise);
      check("a1_done_cycles", dc, 41);
      check("a1_done_cycles_wpc4", dc4, 11);
      check("a1_rd2_rise_cycle", rise, 9);
      rd(4'd10);
      check("a1_r10_valid", rd_valid, 1'b1);
      check("a1_r10", rd_key, R1_10);
      check("a1_r10_wpc4", rd_key4, R1_10);
      rd(4'd0);
      check("a1_r0", rd_key, K1[255:128]);
      rd(4'd1);
      check("a1_r1", rd_key, R1_1);
      rd(4'd2);
      check("a1_r2_wpc4", rd_key4, R1_2);
      rd(4'd11);
      check("a1_r11_invalid", {rd_valid, rd_valid4}, 2'b00);
      check("a1_r11_key", rd_key, 128'h0);

      mode = 2'b11;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ill_err_pulse", {err, err4, ready, busy}, 4'b1110);
      tick();
      check("ill_err_clear", err, 1'b0);
      saw = 1'b0;
      repeat (60) begin
         tick();
         saw = saw | done | done4;
      end
      check("ill_no_done", saw, 1'b0);

      rd_round = 4'd0;
      expand(2'b01, K2, 0, dc, dc4, rise);
      check("a2_done_cycles", dc, 47);
      rd(4'd12);
      check("a2_r12", rd_key, R2_12);
      check("a2_r12_wpc4", rd_key4, R2_12);
      rd(4'd13);
      check("a2_r13_invalid", rd_valid, 1'b0);

      expand(2'b10, K3, 0, dc, dc4, rise);
      check("a3_done_cycles", dc, 53);
      check("a3_done_cycles_wpc4", dc4, 14);
      rd(4'd14);
      check("a3_r14", rd_key, R3_14);
      check("a3_r14_wpc4", rd_key4, R3_14);
      rd(4'd15);
      check("a3_r15_invalid", {rd_valid, rd_key}, 129'h0);

      mode = 2'b00;
      key_in = K1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      check("zero_outputs", {ready, busy, done, err, rd_valid, busy4}, 6'b100000);
      check("zero_rd_key", rd_key, 128'h0);
      saw = 1'b0;
      repeat (50) begin
         tick();
         saw = saw | done | done4;
      end
      check("zero_no_done", saw, 1'b0);
      for (int r = 0; r < 15; r++) begin
         rd(4'(r));
         check($sformatf("zero_r%0d", r), {rd_valid, rd_key}, 129'h0);
      end
      expand(2'b00, K1, 0, dc, dc4, rise);
      check("zero_a1_done_cycles", dc, 41);
      rd(4'd10);
      check("zero_a1_r10", rd_key, R1_10);

      key_in = K1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {ready, busy, done, err, rd_valid, ready4, busy4}, 7'b1000010);
      check("arst_rd_key", rd_key, 128'h0);
      tick();
      rst_n = 1'b1;
      tick();
      rd(4'd0);
      check("arst_r0", {rd_valid, rd_key}, 129'h0);
      expand(2'b00, K1, 0, dc, dc4, rise);
      check("arst_a1_done_cycles", dc, 41);
      rd(4'd10);
      check("arst_a1_r10", rd_key, R1_10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
